// File: rtl/cmp_search.sv
// cmp_search -- successive-approximation operand recovery.
//
// Drives a trial value into an external combinational less-than comparator
// wired as lt = (target < probe), samples the answer once per cycle, and
// after WIDTH probes reports the hidden target.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   search request, honoured only while idle
//   lt      in   comparator result for the current probe
//   probe   out  registered trial value (comparator y input)
//   busy    out  high for the WIDTH probing cycles
//   done    out  one-cycle pulse; result valid from this cycle on
//   result  out  recovered target, held until the next search completes

module cmp_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             lt,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_upd;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] next_bit;
  logic [IDX_W-1:0] idx;
  logic             last_bit;

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = TEST;
      TEST:    if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy and done follow the state directly, so they can
  // never overlap and both drop with the asynchronous reset.
  always_comb begin
    busy = (state == TEST);
    done = (state == DONE);
  end

  // Bit under test and the bit to be tried next.
  always_comb begin
    last_bit = (idx == '0);
    bit_mask = WIDTH'(1) << idx;
    next_bit = bit_mask >> 1;
    // lt=0 means probe <= target, so the trial bit belongs in the answer.
    acc_upd  = lt ? acc : (acc | bit_mask);
  end

  // Search datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      idx    <= '0;
      probe  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            idx   <= IDX_W'(WIDTH - 1);
            probe <= WIDTH'(1) << (WIDTH - 1);
          end
        end
        TEST: begin
          acc <= acc_upd;
          if (last_bit) begin
            // Probe parks at 0 between searches; result only moves here.
            probe  <= '0;
            result <= acc_upd;
          end else begin
            probe <= acc_upd | next_bit;
            idx   <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search.sv
// tb_cmp_search -- self-checking bench for cmp_search (WIDTH=4).
// A behavioural comparator closes the loop: lt = (target < probe).

module tb_cmp_search;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         lt;
  logic [W-1:0] probe;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] target;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]        target;
    logic [3:0][W-1:0]   probes;   // probes[3] is the first probe
    logic [W-1:0]        res;
  } vec_t;

  vec_t vecs[5];

  cmp_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .lt     (lt),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  assign lt = (target < probe);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: pop an expected result on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      check("done_not_busy", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", {28'd0, result}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a done pulse; returns with the done cycle current.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Full search with per-cycle probe/busy checks.
  task automatic run_vec(input vec_t v);
    target = v.target;
    start  = 1'b1;
    exp_q.push_back(v.res);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("probe", {28'd0, probe}, {28'd0, v.probes[3-i]});
      check("busy_in_test", {31'd0, busy}, 32'd1);
      tick();
    end
    check("done_after_w", {31'd0, done}, 32'd1);
    check("probe_parked", {28'd0, probe}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int d0;
    rst_n  = 1'b0;
    start  = 1'b0;
    target = '0;

    vecs[0] = '{target: 4'd9,  probes: {4'd8, 4'd12, 4'd10, 4'd9},  res: 4'd9};
    vecs[1] = '{target: 4'd0,  probes: {4'd8, 4'd4,  4'd2,  4'd1},  res: 4'd0};
    vecs[2] = '{target: 4'd15, probes: {4'd8, 4'd12, 4'd14, 4'd15}, res: 4'd15};
    vecs[3] = '{target: 4'd5,  probes: {4'd8, 4'd4,  4'd6,  4'd5},  res: 4'd5};
    vecs[4] = '{target: 4'd6,  probes: {4'd8, 4'd4,  4'd6,  4'd7},  res: 4'd6};

    #12;
    check("rst_probe",  {28'd0, probe},  32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_result", {28'd0, result}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Exhaustive sweep with gaps.
    for (int t = 0; t < 16; t++) begin
      d0 = done_cnt;
      target = W'(t);
      exp_q.push_back(W'(t));
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("sweep");
      tick();
      tick();
      check("sweep_one_done", d0 + 1, done_cnt);
    end

    // start re-pulsed in TEST and DONE is ignored.
    d0 = done_cnt;
    target = 4'd10;
    exp_q.push_back(4'd10);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;           // TEST cycle 2
    tick();
    start = 1'b0;
    wait_done("ignore");
    start = 1'b1;           // DONE cycle
    tick();
    start = 1'b0;
    check("idle_after_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("ignore_one_done", d0 + 1, done_cnt);
    check("ignore_idle", {31'd0, busy}, 32'd0);

    // Reset during the third TEST cycle.
    d0 = done_cnt;
    target = 4'd9;
    exp_q.push_back(4'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();                 // now in TEST cycle 3
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_probe",  {28'd0, probe},  32'd0);
    check("midrst_busy",   {31'd0, busy},   32'd0);
    check("midrst_result", {28'd0, result}, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_done", done_cnt, d0);
    run_vec(vecs[4]);
    tick();

    // Back-to-back with start held high.
    target = 4'd3;
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd11);
    start = 1'b1;
    tick();
    wait_done("b2b_first");
    target = 4'd11;
    tick();
    wait_done("b2b_second");
    start = 1'b0;
    tick();
    check("b2b_period", last_done_cyc - prev_done_cyc, 6);
    check("b2b_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
